dcache_direct: RTL and testbench

DCACHE_DIRECT -- requirements
Module: dcache_direct

---
 rtl/dcache_pkg.sv | 37 +++
 rtl/dcache_storage.sv | 55 +++++
 rtl/dcache_direct.sv | 131 +++++++++++++
 tb/tb_dcache_direct.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// geometry, field widths, FSM state encoding and word select/merge helpers.
package dcache_pkg;

  localparam int unsigned ADDR_W  = 30;   // processor word address
  localparam int unsigned TAG_W   = 25;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned BADDR_W = TAG_W + IDX_W;  // memory block address
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WORDS   = 4;
  localparam int unsigned LINES   = 8;
  localparam int unsigned BLK_W   = 128;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  // Pick one 32-bit word out of a block; word 0 lives in [31:0].
  function automatic logic [WORD_W-1:0] get_word(input logic [BLK_W-1:0] blk,
                                                 input logic [OFF_W-1:0] off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

  // Replace one word of a block, leaving the others untouched.
  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0]  blk,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [WORD_W-1:0] w);
    logic [BLK_W-1:0] r;
    r = blk;
    r[off*WORD_W +: WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/dcache_storage.sv
// Line storage for the data cache: valid/dirty bits (asynchronously cleared),
// tags and data blocks (not reset).
// Ports:
//   clk, rst_n        clock, async active-low reset (clears valid/dirty)
//   i_rd_idx          line index for the combinational read port
//   o_rd_valid/dirty  state bits of the indexed line
//   o_rd_tag/data     tag and 128-bit block of the indexed line
//   i_we              write enable for the whole line (sets valid)
//   i_wr_idx          line index for the write port
//   i_wr_dirty/tag/data new dirty bit, tag and block
module dcache_storage
  import dcache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic             o_rd_dirty,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [BLK_W-1:0] o_rd_data,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_dirty,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [BLK_W-1:0] i_wr_data
);

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [BLK_W-1:0] r_data [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_dirty[i_wr_idx] <= i_wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 words x 32b.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   proc_read/proc_write    processor load/store request (both high = store)
//   proc_addr[29:0]         word address {tag[29:5], index[4:2], offset[1:0]}
//   proc_wdata[31:0]        store data
//   proc_stall              request cannot complete this cycle
//   proc_rdata[31:0]        load data (valid on read with proc_stall=0)
//   mem_read/mem_write      block fill / block write-back request
//   mem_addr[27:0]          block address {tag, index}
//   mem_wdata[127:0]        victim block, word 0 in [31:0]
//   mem_rdata[127:0]        fill block, valid with mem_ready
//   mem_ready               one-cycle completion pulse from memory
module dcache_direct
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               proc_read,
  input  logic               proc_write,
  input  logic [ADDR_W-1:0]  proc_addr,
  input  logic [WORD_W-1:0]  proc_wdata,
  output logic               proc_stall,
  output logic [WORD_W-1:0]  proc_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]   mem_wdata,
  input  logic [BLK_W-1:0]   mem_rdata,
  input  logic               mem_ready
);

  state_t r_state;
  state_t w_next;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic             w_req;
  logic             w_hit;

  logic             w_rd_valid;
  logic             w_rd_dirty;
  logic [TAG_W-1:0] w_rd_tag;
  logic [BLK_W-1:0] w_rd_data;

  logic             w_we;
  logic             w_wr_dirty;
  logic [BLK_W-1:0] w_wr_data;

  assign w_tag = proc_addr[ADDR_W-1 -: TAG_W];
  assign w_idx = proc_addr[OFF_W +: IDX_W];
  assign w_off = proc_addr[OFF_W-1:0];
  assign w_req = proc_read | proc_write;
  assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

  // Read and write ports share the request index: the processor holds its
  // address through a miss, so the victim and the refilled line coincide.
  dcache_storage u_storage (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_dirty (w_rd_dirty),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_we),
    .i_wr_idx   (w_idx),
    .i_wr_dirty (w_wr_dirty),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COMPARE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      COMPARE:   if (w_req && !w_hit)
                   w_next = (w_rd_valid && w_rd_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ready) w_next = ALLOCATE;
      ALLOCATE:  if (mem_ready) w_next = COMPARE;
      default:   w_next = COMPARE;
    endcase
  end

  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    w_we       = 1'b0;
    w_wr_dirty = 1'b0;
    w_wr_data  = '0;
    case (r_state)
      COMPARE: begin
        proc_stall = w_req && !w_hit;
        if (w_req && w_hit) proc_rdata = get_word(w_rd_data, w_off);
        // A write miss ends up here again after the fill and merges as a hit.
        if (proc_write && w_hit) begin
          w_we       = 1'b1;
          w_wr_dirty = 1'b1;
          w_wr_data  = put_word(w_rd_data, w_off, proc_wdata);
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {w_rd_tag, w_idx};
        mem_wdata  = w_rd_data;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[ADDR_W-1:OFF_W];
        if (mem_ready) begin
          w_we       = 1'b1;
          w_wr_dirty = 1'b0;
          w_wr_data  = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: directed scenarios followed by a
// random load/store stream checked against an architectural memory image and
// a simple line-occupancy model (which block sits in each line, and whether
// it has been stored to since it was fetched).
module tb_dcache_direct;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  dcache_direct dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state for the random phase: 32 blocks (tags 0..3) of memory.
  logic [127:0] bmem [32];   // backing memory seen by the cache's bus
  logic [31:0]  rmem [128];  // architectural value of every word
  bit           mv   [8];
  logic [1:0]   mt   [8];
  bit           md   [8];
  bit           auto_en = 1'b0;
  int           viol = 0;
  int           cnt = 0;
  int           lat = 1;

  function automatic logic [127:0] ref_blk(input logic [4:0] b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = rmem[{b, k[1:0]}];
    return r;
  endfunction

  // Memory responder with random 1..10 cycle latency.
  always @(negedge clk) begin
    if (mem_read && mem_write) viol++;
    if (auto_en) begin
      if (mem_ready) mem_ready = 1'b0;
      else if (mem_read || mem_write) begin
        if (cnt == 0) lat = $urandom_range(1, 10);
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          mem_ready = 1'b1;
          if (mem_write) begin
            chk("wb_addr_range", mem_addr < 28'd32, 1'b1);
            if (mem_addr < 28'd32) begin
              chk("wb_data", mem_wdata, ref_blk(mem_addr[4:0]));
              bmem[mem_addr[4:0]] = mem_wdata;
            end
          end else begin
            mem_rdata = bmem[mem_addr[4:0]];
          end
        end
      end
    end
  end

  // rw: 0/1 load, 2 store, 3 load+store (behaves as store)
  task automatic access(input int rw, input logic [6:0] a7, input logic [31:0] d);
    bit wr, exp_hit, exp_wb, saw_wb, done;
    int idx, cyc;
    logic [1:0] tg;
    wr      = (rw >= 2);
    idx     = int'(a7[4:2]);
    tg      = a7[6:5];
    exp_hit = mv[idx] && (mt[idx] == tg);
    exp_wb  = !exp_hit && mv[idx] && md[idx];
    @(negedge clk);
    proc_read  = (rw != 2);
    proc_write = wr;
    proc_addr  = {23'd0, a7};
    proc_wdata = d;
    #4;
    chk("first_stall", proc_stall, !exp_hit);
    saw_wb = 1'b0;
    done   = 1'b0;
    cyc    = 0;
    while (!done && cyc < 200) begin
      if (mem_write) saw_wb = 1'b1;
      if (!proc_stall) done = 1'b1;
      else begin
        @(negedge clk);
        #4;
        cyc++;
      end
    end
    chk("done", done, 1'b1);
    if (!exp_hit) chk("wb_seen", saw_wb, exp_wb);
    if (!wr && done) chk("rdata", proc_rdata, rmem[a7]);
    if (wr) rmem[a7] = d;
    if (exp_hit) begin
      if (wr) md[idx] = 1'b1;
    end else begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
      md[idx] = wr;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_stall", proc_stall, 1'b0);
    chk("rst_mrd", mem_read, 1'b0);
    chk("rst_mwr", mem_write, 1'b0);
    chk("rst_rdata", proc_rdata, 32'h0);
    chk("rst_maddr", mem_addr, 28'h0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    // Cold read miss and fill
    @(negedge clk); proc_read = 1'b1; proc_addr = 30'h1; #4;
    chk("d1_stall", proc_stall, 1'b1);
    chk("d1_cmp_mrd", mem_read, 1'b0);
    @(negedge clk); #4;
    chk("d1_mrd", mem_read, 1'b1);
    chk("d1_maddr", mem_addr, 28'h0);
    chk("d1_mwr", mem_write, 1'b0);
    @(negedge clk); mem_ready = 1'b1; mem_rdata = {4{32'hA5A5A5A5}}; #4;
    @(negedge clk); mem_ready = 1'b0; #4;
    chk("d1_stall_after", proc_stall, 1'b0);
    chk("d1_rdata", proc_rdata, 32'hA5A5A5A5);

    // Read hit, zero wait
    @(negedge clk); proc_addr = 30'h2; #4;
    chk("d2_stall", proc_stall, 1'b0);
    chk("d2_rdata", proc_rdata, 32'hA5A5A5A5);
    chk("d2_mem", mem_read | mem_write, 1'b0);

    // Write hit, then conflicting read forces write-back
    @(negedge clk); proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h3;
    proc_wdata = 32'hDEADBEEF; #4;
    chk("d3_wstall", proc_stall, 1'b0);
    @(negedge clk); proc_write = 1'b0; proc_read = 1'b1; proc_addr = 30'h23; #4;
    chk("d3_miss", proc_stall, 1'b1);
    @(negedge clk); #4;
    chk("d3_mwr", mem_write, 1'b1);
    chk("d3_mrd_off", mem_read, 1'b0);
    chk("d3_waddr", mem_addr, 28'h0);
    chk("d3_wtop", mem_wdata[127:96], 32'hDEADBEEF);
    chk("d3_wlow", mem_wdata[31:0], 32'hA5A5A5A5);
    @(negedge clk); mem_ready = 1'b1; #4;
    @(negedge clk); mem_ready = 1'b0; #4;
    chk("d3_mrd", mem_read, 1'b1);
    chk("d3_raddr", mem_addr, 28'h8);
    chk("d3_mwr_off", mem_write, 1'b0);
    @(negedge clk); mem_ready = 1'b1;
    mem_rdata = {32'h44, 32'h33, 32'h22, 32'h11}; #4;
    @(negedge clk); mem_ready = 1'b0; #4;
    chk("d3_stall_after", proc_stall, 1'b0);
    chk("d3_rdata", proc_rdata, 32'h44);

    // Write miss to a clean line: fill only, then merge
    @(negedge clk); proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h44;
    proc_wdata = 32'h12345678; #4;
    chk("d4_stall", proc_stall, 1'b1);
    @(negedge clk); #4;
    chk("d4_mrd", mem_read, 1'b1);
    chk("d4_mwr", mem_write, 1'b0);
    chk("d4_addr", mem_addr, 28'h11);
    @(negedge clk); mem_ready = 1'b1; mem_rdata = {4{32'hCAFEF00D}}; #4;
    @(negedge clk); mem_ready = 1'b0; #4;
    chk("d4_merge_stall", proc_stall, 1'b0);
    @(negedge clk); proc_write = 1'b0; proc_read = 1'b1; #4;
    chk("d4_rd_stall", proc_stall, 1'b0);
    chk("d4_rdata", proc_rdata, 32'h12345678);
    @(negedge clk); proc_addr = 30'h64; #4;
    chk("d4_evict_stall", proc_stall, 1'b1);
    @(negedge clk); #4;
    chk("d4_dirty_wb", mem_write, 1'b1);
    chk("d4_wb_addr", mem_addr, 28'h11);
    chk("d4_wb_w0", mem_wdata[31:0], 32'h12345678);
    chk("d4_wb_w1", mem_wdata[63:32], 32'hCAFEF00D);
    @(negedge clk); mem_ready = 1'b1; #4;
    @(negedge clk); mem_ready = 1'b0; #4;
    chk("d5_mrd", mem_read, 1'b1);
    chk("d5_addr", mem_addr, 28'h19);

    // Reset in the middle of a fill
    #3; rst_n = 1'b0; #1;
    chk("d5_rst_mrd", mem_read, 1'b0);
    chk("d5_rst_maddr", mem_addr, 28'h0);
    chk("d5_rst_rdata", proc_rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1; #4;
    chk("d5_remiss", proc_stall, 1'b1);
    @(negedge clk); #4;
    chk("d5_realloc", mem_read, 1'b1);
    chk("d5_nowb", mem_write, 1'b0);

    // Random phase
    @(negedge clk); proc_read = 1'b0; proc_write = 1'b0; rst_n = 1'b0;
    for (int b = 0; b < 32; b++) begin
      bmem[b] = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 4; k++) rmem[b*4 + k] = bmem[b][32*k +: 32];
    end
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 2'd0; end
    @(negedge clk); rst_n = 1'b1; auto_en = 1'b1;
    for (int n = 0; n < 400; n++)
      access(int'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), $urandom);

    @(negedge clk); proc_read = 1'b0; proc_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("rw_excl", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
